// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer and its datapath muxes.
// Also provides the per-state control decode and the DECODE dispatch table.
package mc_pkg;

   typedef enum logic [3:0] {
      S_INIT     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_EXEC_I   = 4'd4,
      S_MEM_ADDR = 4'd5,
      S_MEM_RD   = 4'd6,
      S_MEM_WB   = 4'd7,
      S_MEM_WR   = 4'd8,
      S_WB_R     = 4'd9,
      S_WB_I     = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_HALT     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LUI = 3'd3
   } alu_op_t;

   typedef enum logic [1:0] {
      SRCB_RT = 2'd0, SRCB_4 = 2'd1, SRCB_EXT = 2'd2, SRCB_EXT_SH2 = 2'd3
   } alu_src_b_t;

   typedef enum logic [1:0] {
      EXT_ZERO = 2'd0, EXT_SIGN = 2'd1
   } ext_op_t;

   typedef enum logic [1:0] {
      DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2
   } reg_dst_t;

   typedef enum logic [1:0] {
      WSRC_ALUOUT = 2'd0, WSRC_MDR = 2'd1, WSRC_PC = 2'd3
   } reg_src_t;

   typedef enum logic [1:0] {
      NPC_ALU = 2'd0, NPC_ALUOUT = 2'd1, NPC_JUMP = 2'd2, NPC_RS = 2'd3
   } npc_src_t;

   typedef enum logic [3:0] {
      CLS_ILLEGAL, CLS_ADDU, CLS_SUBU, CLS_NOP, CLS_JR, CLS_ORI,
      CLS_LUI, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_JAL
   } cls_t;

   // Moore part of the control word; FETCH/BRANCH pc_write and ir_write are added in the top.
   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       pc_write;
      logic       reg_write;
      alu_op_t    alu_op;
      logic       alu_src_a;
      alu_src_b_t alu_src_b;
      ext_op_t    ext_op;
      reg_dst_t   reg_dst;
      reg_src_t   reg_src;
      npc_src_t   npc_src;
      logic       halted;
   } ctl_t;

   function automatic ctl_t ctl_for(state_t s, cls_t c);
      ctl_t k;
      k = '0;
      case (s)
         S_FETCH: begin
            k.mem_req   = 1'b1;
            k.alu_src_b = SRCB_4;
         end
         S_DECODE: begin
            k.alu_src_b = SRCB_EXT_SH2;
            k.ext_op    = EXT_SIGN;
         end
         S_EXEC_R: begin
            k.alu_src_a = 1'b1;
            k.alu_op    = (c == CLS_SUBU) ? ALU_SUB : ALU_ADD;
         end
         S_EXEC_I: begin
            k.alu_src_a = 1'b1;
            k.alu_src_b = SRCB_EXT;
            k.alu_op    = (c == CLS_LUI) ? ALU_LUI : ALU_OR;
         end
         S_MEM_ADDR: begin
            k.alu_src_a = 1'b1;
            k.alu_src_b = SRCB_EXT;
            k.ext_op    = EXT_SIGN;
         end
         S_MEM_RD: k.mem_req = 1'b1;
         S_MEM_WR: begin
            k.mem_req   = 1'b1;
            k.mem_write = 1'b1;
         end
         S_WB_R: begin
            k.reg_write = 1'b1;
            k.reg_dst   = DST_RD;
         end
         S_WB_I:   k.reg_write = 1'b1;
         S_MEM_WB: begin
            k.reg_write = 1'b1;
            k.reg_src   = WSRC_MDR;
         end
         S_BRANCH: begin
            k.alu_src_a = 1'b1;
            k.alu_op    = ALU_SUB;
            k.npc_src   = NPC_ALUOUT;
         end
         S_JUMP: begin
            k.pc_write = 1'b1;
            k.npc_src  = (c == CLS_JR) ? NPC_RS : NPC_JUMP;
            if (c == CLS_JAL) begin
               k.reg_write = 1'b1;
               k.reg_dst   = DST_RA;
               k.reg_src   = WSRC_PC;
            end
         end
         S_HALT:  k.halted = 1'b1;
         default: k = '0;
      endcase
      return k;
   endfunction

   function automatic state_t dispatch(cls_t c);
      state_t s;
      case (c)
         CLS_ADDU, CLS_SUBU:      s = S_EXEC_R;
         CLS_NOP:                 s = S_FETCH;
         CLS_JR, CLS_J, CLS_JAL:  s = S_JUMP;
         CLS_ORI, CLS_LUI:        s = S_EXEC_I;
         CLS_LW, CLS_SW:          s = S_MEM_ADDR;
         CLS_BEQ:                 s = S_BRANCH;
         default:                 s = S_HALT;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/ready handshake between the sequencer (master) and instruction/data memory.
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_write;
   logic mem_ready;

   modport master (output mem_req, output mem_write, input mem_ready);
   modport slave  (input mem_req, input mem_write, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational op/funct -> instruction class; unsupported encodings map to CLS_ILLEGAL.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   output cls_t       o_cls
);

   always_comb begin
      o_cls = CLS_ILLEGAL;
      case (i_op)
         OP_RTYPE: begin
            case (i_funct)
               FN_ADDU: o_cls = CLS_ADDU;
               FN_SUBU: o_cls = CLS_SUBU;
               FN_SLL:  o_cls = CLS_NOP;
               FN_JR:   o_cls = CLS_JR;
               default: o_cls = CLS_ILLEGAL;
            endcase
         end
         OP_ORI:  o_cls = CLS_ORI;
         OP_LUI:  o_cls = CLS_LUI;
         OP_LW:   o_cls = CLS_LW;
         OP_SW:   o_cls = CLS_SW;
         OP_BEQ:  o_cls = CLS_BEQ;
         OP_J:    o_cls = CLS_J;
         OP_JAL:  o_cls = CLS_JAL;
         default: o_cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: registered FSM driving datapath selects and strobes.
// Optional performance counters (cycle_cnt, instr_cnt) when MULTICYCLE_PERF_EN is defined.
module multicycle_ctrl
   import mc_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [5:0]               op,
   input  logic [5:0]               funct,
   input  logic                     zero,
   multicycle_ctrl_if.master        mem,
   output logic                     ir_write,
   output logic                     pc_write,
   output logic                     reg_write,
   output logic [2:0]               alu_op,
   output logic                     alu_src_a,
   output logic [1:0]               alu_src_b,
   output logic [1:0]               ext_op,
   output logic [1:0]               reg_dst,
   output logic [1:0]               reg_src,
   output logic [1:0]               npc_src,
   output logic [3:0]               state,
   output logic                     halted
`ifdef MULTICYCLE_PERF_EN
   ,
   output logic [31:0]              cycle_cnt,
   output logic [31:0]              instr_cnt
`endif
);

   state_t r_state;
   ctl_t   r_ctl;
   state_t w_next;
   cls_t   w_cls;

   mc_decode u_decode (
      .i_op    (op),
      .i_funct (funct),
      .o_cls   (w_cls)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:     w_next = S_FETCH;
         S_FETCH:    if (mem.mem_ready) w_next = S_DECODE;
         S_DECODE:   w_next = dispatch(w_cls);
         S_EXEC_R:   w_next = S_WB_R;
         S_EXEC_I:   w_next = S_WB_I;
         S_MEM_ADDR: w_next = (w_cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem.mem_ready) w_next = S_MEM_WB;
         S_MEM_WR:   if (mem.mem_ready) w_next = S_FETCH;
         S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
         S_HALT:     w_next = S_HALT;
         default:    w_next = S_HALT;
      endcase
   end

   // Control word is precomputed for the state being entered, so outputs come straight from flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_INIT;
         r_ctl   <= '0;
      end else begin
         r_state <= w_next;
         r_ctl   <= ctl_for(w_next, w_cls);
      end
   end

   assign mem.mem_req   = r_ctl.mem_req;
   assign mem.mem_write = r_ctl.mem_write;
   assign ir_write      = (r_state == S_FETCH) && mem.mem_ready;
   assign pc_write      = r_ctl.pc_write
                        || ((r_state == S_FETCH) && mem.mem_ready)
                        || ((r_state == S_BRANCH) && zero);
   assign reg_write     = r_ctl.reg_write;
   assign alu_op        = r_ctl.alu_op;
   assign alu_src_a     = r_ctl.alu_src_a;
   assign alu_src_b     = r_ctl.alu_src_b;
   assign ext_op        = r_ctl.ext_op;
   assign reg_dst       = r_ctl.reg_dst;
   assign reg_src       = r_ctl.reg_src;
   assign npc_src       = r_ctl.npc_src;
   assign halted        = r_ctl.halted;
   assign state         = r_state;

`ifdef MULTICYCLE_PERF_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instr_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         if ((r_state != S_INIT) && (r_state != S_HALT))
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if ((w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_INIT))
            r_instr_cnt <= r_instr_cnt + 32'd1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
   assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised instruction-level bench for multicycle_ctrl with a per-cycle scoreboard.
module tb_multicycle_ctrl;
   import mc_pkg::*;

   typedef struct packed {
      logic [3:0]  st;
      logic        req, wr, irw, pcw, rgw;
      logic [2:0]  aop;
      logic        asa;
      logic [1:0]  asb, ext, dst, src, npc;
      logic        hlt;
      logic [31:0] cyc, ins;
   } rec_t;

   typedef enum int {
      I_ADDU, I_SUBU, I_NOP, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD
   } ins_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] op = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       ir_write, pc_write, reg_write, alu_src_a, halted;
   logic [2:0] alu_op;
   logic [1:0] alu_src_b, ext_op, reg_dst, reg_src, npc_src;
   logic [3:0] state;
`ifdef MULTICYCLE_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   multicycle_ctrl_if mem ();

   multicycle_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .funct     (funct),
      .zero      (zero),
      .mem       (mem),
      .ir_write  (ir_write),
      .pc_write  (pc_write),
      .reg_write (reg_write),
      .alu_op    (alu_op),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .ext_op    (ext_op),
      .reg_dst   (reg_dst),
      .reg_src   (reg_src),
      .npc_src   (npc_src),
      .state     (state),
      .halted    (halted)
`ifdef MULTICYCLE_PERF_EN
      ,
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   rec_t        q[$];
   int          total = 0;
   int          bad = 0;
   int unsigned m_cyc = 0;
   int unsigned m_ins = 0;
   logic [3:0]  m_prev = S_INIT;

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic rec_t mk(state_t s);
      rec_t e;
      e = '0;
      e.st = s;
      return e;
   endfunction

   // One clock of stimulus: drive inputs, record what the outputs must be during this cycle.
   task automatic tick(input rec_t e, input logic rdy, input logic z);
      mem.mem_ready = rdy;
      zero = z;
      if (e.st == S_FETCH && m_prev != S_FETCH && m_prev != S_INIT) m_ins++;
`ifdef MULTICYCLE_PERF_EN
      e.cyc = m_cyc;
      e.ins = m_ins;
`endif
      if (e.st != S_INIT && e.st != S_HALT) m_cyc++;
      m_prev = e.st;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      m_cyc = 0;
      m_ins = 0;
      tick(mk(S_INIT), rnd(), rnd());
      tick(mk(S_INIT), rnd(), rnd());
      reset = 1'b1;
      tick(mk(S_INIT), rnd(), rnd());
   endtask

   task automatic fetch(input int unsigned w);
      rec_t e;
      e = mk(S_FETCH);
      e.req = 1'b1;
      e.asb = 2'd1;
      for (int unsigned i = 0; i < w; i++) tick(e, 1'b0, rnd());
      e.irw = 1'b1;
      e.pcw = 1'b1;
      tick(e, 1'b1, rnd());
   endtask

   task automatic fetch_abort(input int unsigned w);
      rec_t e;
      op = 6'($urandom);
      funct = 6'($urandom);
      e = mk(S_FETCH);
      e.req = 1'b1;
      e.asb = 2'd1;
      for (int unsigned i = 0; i < w; i++) tick(e, 1'b0, rnd());
      do_reset();
   endtask

   task automatic set_opcode(input ins_t k);
      funct = 6'($urandom);
      case (k)
         I_ADDU: begin op = 6'h00; funct = 6'h21; end
         I_SUBU: begin op = 6'h00; funct = 6'h23; end
         I_NOP:  begin op = 6'h00; funct = 6'h00; end
         I_JR:   begin op = 6'h00; funct = 6'h08; end
         I_ORI:  op = 6'h0D;
         I_LUI:  op = 6'h0F;
         I_LW:   op = 6'h23;
         I_SW:   op = 6'h2B;
         I_BEQ:  op = 6'h04;
         I_J:    op = 6'h02;
         I_JAL:  op = 6'h03;
         default: begin
            case ($urandom_range(0, 2))
               0:       op = 6'h3F;
               1:       begin op = 6'h00; funct = 6'h20; end
               default: op = 6'h08;
            endcase
         end
      endcase
   endtask

   // Whole instruction: fetch with fw stalls, decode, class-specific steps, mw memory stalls.
   task automatic run_instr(input ins_t k, input int unsigned fw, input int unsigned mw,
                            input logic z);
      rec_t e;
      op = 6'($urandom);
      funct = 6'($urandom);
      fetch(fw);
      set_opcode(k);
      e = mk(S_DECODE);
      e.asb = 2'd3;
      e.ext = 2'd1;
      tick(e, rnd(), rnd());
      case (k)
         I_ADDU, I_SUBU: begin
            e = mk(S_EXEC_R);
            e.asa = 1'b1;
            e.aop = (k == I_SUBU) ? 3'd1 : 3'd0;
            tick(e, rnd(), rnd());
            e = mk(S_WB_R);
            e.rgw = 1'b1;
            e.dst = 2'd1;
            tick(e, rnd(), rnd());
         end
         I_ORI, I_LUI: begin
            e = mk(S_EXEC_I);
            e.asa = 1'b1;
            e.asb = 2'd2;
            e.aop = (k == I_LUI) ? 3'd3 : 3'd2;
            tick(e, rnd(), rnd());
            e = mk(S_WB_I);
            e.rgw = 1'b1;
            tick(e, rnd(), rnd());
         end
         I_LW, I_SW: begin
            e = mk(S_MEM_ADDR);
            e.asa = 1'b1;
            e.asb = 2'd2;
            e.ext = 2'd1;
            tick(e, rnd(), rnd());
            e = mk((k == I_LW) ? S_MEM_RD : S_MEM_WR);
            e.req = 1'b1;
            e.wr = (k == I_SW);
            for (int unsigned i = 0; i < mw; i++) tick(e, 1'b0, rnd());
            tick(e, 1'b1, rnd());
            if (k == I_LW) begin
               e = mk(S_MEM_WB);
               e.rgw = 1'b1;
               e.src = 2'd1;
               tick(e, rnd(), rnd());
            end
         end
         I_BEQ: begin
            e = mk(S_BRANCH);
            e.asa = 1'b1;
            e.aop = 3'd1;
            e.npc = 2'd1;
            e.pcw = z;
            tick(e, rnd(), z);
         end
         I_J, I_JAL, I_JR: begin
            e = mk(S_JUMP);
            e.pcw = 1'b1;
            e.npc = (k == I_JR) ? 2'd3 : 2'd2;
            if (k == I_JAL) begin
               e.rgw = 1'b1;
               e.dst = 2'd2;
               e.src = 2'd3;
            end
            tick(e, rnd(), rnd());
         end
         I_BAD: begin
            e = mk(S_HALT);
            e.hlt = 1'b1;
            for (int unsigned i = 0; i < 3 + $urandom_range(0, 4); i++) tick(e, rnd(), rnd());
            do_reset();
         end
         default: ;
      endcase
   endtask

   initial begin : monitor
      rec_t e, a;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            a = '0;
            a.st  = state;
            a.req = mem.mem_req;
            a.wr  = mem.mem_write;
            a.irw = ir_write;
            a.pcw = pc_write;
            a.rgw = reg_write;
            a.aop = alu_op;
            a.asa = alu_src_a;
            a.asb = alu_src_b;
            a.ext = ext_op;
            a.dst = reg_dst;
            a.src = reg_src;
            a.npc = npc_src;
            a.hlt = halted;
`ifdef MULTICYCLE_PERF_EN
            a.cyc = cycle_cnt;
            a.ins = instr_cnt;
`endif
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL outputs t=%0t got=%h exp=%h", $time, a, e);
            end
         end
      end
   end

   initial begin : stim
      ins_t        k;
      int unsigned r, fw;
      mem.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
      run_instr(I_ADDU, 0, 0, 1'b0);
      run_instr(I_LW,   0, 2, 1'b0);
      run_instr(I_BEQ,  0, 0, 1'b1);
      run_instr(I_BEQ,  0, 0, 1'b0);
      run_instr(I_JAL,  0, 0, 1'b0);
      run_instr(I_JR,   1, 0, 1'b1);
      run_instr(I_J,    0, 0, 1'b0);
      run_instr(I_NOP,  2, 0, 1'b0);
      run_instr(I_ORI,  0, 0, 1'b0);
      run_instr(I_LUI,  0, 0, 1'b0);
      run_instr(I_SUBU, 0, 0, 1'b1);
      run_instr(I_SW,   0, 3, 1'b0);
      run_instr(I_BAD,  0, 0, 1'b0);
      fetch_abort(2);
      run_instr(I_ADDU, 0, 0, 1'b0);
      run_instr(I_SW,   0, 0, 1'b0);
      run_instr(I_BEQ,  0, 0, 1'b1);
      run_instr(I_LW,   0, 0, 1'b0);
      for (int unsigned n = 0; n < 160; n++) begin
         r = $urandom_range(0, 39);
         if (r == 1) begin
            fetch_abort($urandom_range(0, 3));
         end else begin
            k  = (r == 0) ? I_BAD : ins_t'(int'(r % 11));
            fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(k, fw, $urandom_range(0, 3), rnd());
         end
      end
      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d required=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
